// File: rtl/dds_cmd_parser.sv
// UART command-frame parser for a two-channel DDS: A5 CH CMD D_HI D_LO CS.
// Validates each frame and strobes parameter writes and a result ack one cycle after the CS byte.
module dds_cmd_parser #(
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_vld,
   output logic [15:0] o_dds1_val,
   output logic [7:0]  o_dds1_vld,
   output logic [15:0] o_dds2_val,
   output logic [7:0]  o_dds2_vld,
   output logic        o_ack_vld,
   output logic [1:0]  o_ack_code
);

   localparam int unsigned GapW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {StIdle, StCh, StCmd, StDhi, StDlo, StCs} state_e;

   state_e            state_q, state_d, state_cur;
   logic [GapW-1:0]   gap_q, gap_d;
   logic [7:0]        ch_q, ch_d, cmd_q, cmd_d, dhi_q, dhi_d, dlo_q, dlo_d;
   logic [15:0]       val1_q, val1_d, val2_q, val2_d;
   logic [7:0]        vld1_q, vld1_d, vld2_q, vld2_d;
   logic              ack_vld_q, ack_vld_d;
   logic [1:0]        ack_code_q, ack_code_d;

   logic              timeout;
   logic [7:0]        sum;
   logic [15:0]       dval, dmax;
   logic [1:0]        code;

   always_comb begin
      case (cmd_q[2:0])
         3'd0:    dmax = 16'd1;
         3'd1:    dmax = 16'd7;
         3'd2:    dmax = 16'd50000;
         3'd3:    dmax = 16'd3000;
         3'd4:    dmax = 16'd6000;
         3'd5:    dmax = 16'd6000;
         3'd6:    dmax = 16'd3600;
         default: dmax = 16'd1000;
      endcase
   end

   // Checksum error outranks a bad channel/cmd, which outranks out-of-range data.
   always_comb begin
      sum  = ch_q + cmd_q + dhi_q + dlo_q;
      dval = {dhi_q, dlo_q};
      if (sum != i_rx_data) begin
         code = 2'd1;
      end else if (ch_q < 8'h01 || ch_q > 8'h03 || cmd_q > 8'h07) begin
         code = 2'd2;
      end else if (dval > dmax) begin
         code = 2'd3;
      end else begin
         code = 2'd0;
      end
   end

   always_comb begin
      // A timed-out frame is dropped first, so a byte arriving that cycle is seen from idle.
      timeout    = (state_q != StIdle) && (gap_q == GapW'(TIMEOUT_CYC));
      state_cur  = timeout ? StIdle : state_q;
      state_d    = state_cur;
      gap_d      = timeout ? '0 : gap_q;
      ch_d       = ch_q;
      cmd_d      = cmd_q;
      dhi_d      = dhi_q;
      dlo_d      = dlo_q;
      val1_d     = val1_q;
      val2_d     = val2_q;
      vld1_d     = 8'h00;
      vld2_d     = 8'h00;
      ack_vld_d  = 1'b0;
      ack_code_d = ack_code_q;
      if (i_rx_vld) begin
         gap_d = '0;
         case (state_cur)
            StIdle: if (i_rx_data == 8'hA5) state_d = StCh;
            StCh: begin
               ch_d    = i_rx_data;
               state_d = StCmd;
            end
            StCmd: begin
               cmd_d   = i_rx_data;
               state_d = StDhi;
            end
            StDhi: begin
               dhi_d   = i_rx_data;
               state_d = StDlo;
            end
            StDlo: begin
               dlo_d   = i_rx_data;
               state_d = StCs;
            end
            default: begin
               state_d    = StIdle;
               ack_vld_d  = 1'b1;
               ack_code_d = code;
               if (code == 2'd0) begin
                  if (ch_q[0]) begin
                     val1_d = dval;
                     vld1_d = 8'h01 << cmd_q[2:0];
                  end
                  if (ch_q[1]) begin
                     val2_d = dval;
                     vld2_d = 8'h01 << cmd_q[2:0];
                  end
               end
            end
         endcase
      end else if (state_cur != StIdle) begin
         gap_d = gap_q + GapW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= StIdle;
         gap_q      <= '0;
         ch_q       <= 8'h00;
         cmd_q      <= 8'h00;
         dhi_q      <= 8'h00;
         dlo_q      <= 8'h00;
         val1_q     <= 16'h0000;
         val2_q     <= 16'h0000;
         vld1_q     <= 8'h00;
         vld2_q     <= 8'h00;
         ack_vld_q  <= 1'b0;
         ack_code_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         ch_q       <= ch_d;
         cmd_q      <= cmd_d;
         dhi_q      <= dhi_d;
         dlo_q      <= dlo_d;
         val1_q     <= val1_d;
         val2_q     <= val2_d;
         vld1_q     <= vld1_d;
         vld2_q     <= vld2_d;
         ack_vld_q  <= ack_vld_d;
         ack_code_q <= ack_code_d;
      end
   end

   assign o_dds1_val = val1_q;
   assign o_dds1_vld = vld1_q;
   assign o_dds2_val = val2_q;
   assign o_dds2_vld = vld2_q;
   assign o_ack_vld  = ack_vld_q;
   assign o_ack_code = ack_code_q;

endmodule

// File: tb/tb_dds_cmd_parser.sv
// Bench for dds_cmd_parser: directed frames with literal expectations, then random traffic
// compared every cycle against a frame-buffer model of the protocol.
module tb_dds_cmd_parser;

   localparam int unsigned Tmo = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_vld = 1'b0;
   logic [15:0] dds1_val, dds2_val;
   logic [7:0]  dds1_vld, dds2_vld;
   logic        ack_vld;
   logic [1:0]  ack_code;

   int n_pass = 0;
   int n_total = 0;
   int ack_seen = 0;

   dds_cmd_parser #(.TIMEOUT_CYC(Tmo)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_rx_data  (rx_data),
      .i_rx_vld   (rx_vld),
      .o_dds1_val (dds1_val),
      .o_dds1_vld (dds1_vld),
      .o_dds2_val (dds2_val),
      .o_dds2_vld (dds2_vld),
      .o_ack_vld  (ack_vld),
      .o_ack_code (ack_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic int unsigned max_of(input logic [7:0] c);
      case (c)
         8'd0: return 1;
         8'd1: return 7;
         8'd2: return 50000;
         8'd3: return 3000;
         8'd4: return 6000;
         8'd5: return 6000;
         8'd6: return 3600;
         default: return 1000;
      endcase
   endfunction

   // Reference model: collect frame bytes in an array, judge the frame when six are in.
   logic [7:0]  fr [6];
   int          nbytes = 0;
   int          gap = 0;
   logic        exp_ack = 1'b0;
   logic [1:0]  exp_code = 2'd0;
   logic [15:0] exp_v1 = 16'h0, exp_v2 = 16'h0;
   logic [7:0]  exp_l1 = 8'h0, exp_l2 = 8'h0;

   always @(posedge clk or negedge rst_n) begin
      logic [7:0]  s;
      logic [15:0] dv;
      if (!rst_n) begin
         nbytes = 0; gap = 0; exp_ack = 1'b0; exp_code = 2'd0;
         exp_v1 = 16'h0; exp_v2 = 16'h0; exp_l1 = 8'h0; exp_l2 = 8'h0;
      end else begin
         exp_ack = 1'b0; exp_l1 = 8'h0; exp_l2 = 8'h0;
         if (nbytes != 0 && gap == Tmo) begin
            nbytes = 0; gap = 0;
         end
         if (rx_vld) begin
            if (nbytes == 0) begin
               if (rx_data == 8'hA5) begin
                  fr[0] = rx_data; nbytes = 1; gap = 0;
               end
            end else begin
               fr[nbytes] = rx_data; nbytes++; gap = 0;
               if (nbytes == 6) begin
                  nbytes = 0;
                  s  = fr[1] + fr[2] + fr[3] + fr[4];
                  dv = {fr[3], fr[4]};
                  if (s != fr[5]) exp_code = 2'd1;
                  else if (!(fr[1] inside {8'h01, 8'h02, 8'h03}) || fr[2] > 8'h07) exp_code = 2'd2;
                  else if (int'(dv) > max_of(fr[2])) exp_code = 2'd3;
                  else exp_code = 2'd0;
                  exp_ack = 1'b1;
                  if (exp_code == 2'd0) begin
                     if (fr[1][0]) begin exp_v1 = dv; exp_l1 = 8'h01 << fr[2][2:0]; end
                     if (fr[1][1]) begin exp_v2 = dv; exp_l2 = 8'h01 << fr[2][2:0]; end
                  end
               end
            end
         end else if (nbytes != 0) begin
            gap++;
         end
      end
   end

   always @(negedge clk) begin
      check("ack_vld", 32'(ack_vld), 32'(exp_ack));
      if (exp_ack || !rst_n) check("ack_code", 32'(ack_code), 32'(exp_code));
      check("dds1_vld", 32'(dds1_vld), 32'(exp_l1));
      check("dds2_vld", 32'(dds2_vld), 32'(exp_l2));
      check("dds1_val", 32'(dds1_val), 32'(exp_v1));
      check("dds2_val", 32'(dds2_val), 32'(exp_v2));
      if (ack_vld) ack_seen++;
   end

   // Drivers: called at posedge+1, return at posedge+1.
   task automatic send(input logic [7:0] b);
      rx_data = b;
      rx_vld  = 1'b1;
      @(posedge clk);
      #1 rx_vld = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send6(input logic [47:0] f);
      for (int i = 0; i < 6; i++) send(f[47-8*i -: 8]);
   endtask

   task automatic rand_frame(input logic [7:0] ch, input logic [7:0] cmd, input logic [15:0] d,
                             input bit bad_cs, input int gap_max, input int long_at,
                             input int long_len);
      logic [7:0] b [6];
      b[0] = 8'hA5; b[1] = ch; b[2] = cmd; b[3] = d[15:8]; b[4] = d[7:0];
      b[5] = ch + cmd + d[15:8] + d[7:0];
      if (bad_cs) b[5] = b[5] ^ 8'(($urandom_range(1, 255)));
      for (int i = 0; i < 6; i++) begin
         send(b[i]);
         if (i < 5 && gap_max > 0) idle($urandom_range(0, gap_max));
         if (i == long_at) idle(long_len);
      end
   endtask

   task automatic pulse_reset;
      #2 rst_n = 1'b0;
      #1 check("async_rst_val1", 32'(dds1_val), 32'h0);
      check("async_rst_vld1", 32'(dds1_vld), 32'h0);
      idle(2);
      rst_n = 1'b1;
   endtask

   initial begin
      int ack0;
      #1 check("rst_val1", 32'(dds1_val), 32'h0);
      check("rst_ack", 32'(ack_vld), 32'h0);
      idle(3);
      rst_n = 1'b1;
      idle(2);

      send6(48'hA5_01_02_C3_50_16);
      check("f1_vld1", 32'(dds1_vld), 32'h04);
      check("f1_val1", 32'(dds1_val), 32'hC350);
      check("f1_code", 32'(ack_code), 32'd0);
      check("f1_ack", 32'(ack_vld), 32'd1);
      check("f1_val2", 32'(dds2_val), 32'h0);
      check("f1_vld2", 32'(dds2_vld), 32'h0);

      send6(48'hA5_03_07_03_E8_F5);
      check("f2_vld1", 32'(dds1_vld), 32'h80);
      check("f2_vld2", 32'(dds2_vld), 32'h80);
      check("f2_val1", 32'(dds1_val), 32'd1000);
      check("f2_val2", 32'(dds2_val), 32'd1000);
      check("f2_code", 32'(ack_code), 32'd0);
      check("model_v1", 32'(exp_v1), 32'd1000);

      send6(48'hA5_01_03_0B_B9_C8);
      check("range_code", 32'(ack_code), 32'd3);
      check("range_vld1", 32'(dds1_vld), 32'h0);
      check("range_val1", 32'(dds1_val), 32'd1000);

      send6(48'hA5_01_02_C3_50_17);
      check("cs_code", 32'(ack_code), 32'd1);
      send6(48'hA5_04_00_00_01_05);
      check("ch_code", 32'(ack_code), 32'd2);
      send6(48'hA5_01_08_00_00_09);
      check("cmd_code", 32'(ack_code), 32'd2);
      check("model_code", 32'(exp_code), 32'd2);

      idle(1);
      ack0 = ack_seen;
      send(8'hA5);
      send(8'h01);
      idle(Tmo);
      send6(48'hA5_02_06_0E_10_26);
      check("tmo_val2", 32'(dds2_val), 32'd3600);
      check("tmo_vld2", 32'(dds2_vld), 32'h40);
      idle(1);
      check("tmo_acks", 32'(ack_seen - ack0), 32'd1);

      send(8'hA5); send(8'h01); send(8'h02); send(8'hC3);
      pulse_reset();
      check("rst_val2", 32'(dds2_val), 32'h0);
      send6(48'hA5_01_00_00_01_02);
      check("post_rst_val1", 32'(dds1_val), 32'd1);
      check("post_rst_vld1", 32'(dds1_vld), 32'h01);

      for (int it = 0; it < 300; it++) begin
         int unsigned r;
         logic [7:0]  ch, cmd;
         logic [15:0] d;
         r   = $urandom_range(0, 19);
         ch  = 8'($urandom_range(1, 3));
         cmd = 8'($urandom_range(0, 7));
         d   = 16'($urandom_range(0, max_of(cmd) + 1));
         if (r == 0) ch = 8'($urandom_range(0, 255));
         if (r == 1) cmd = 8'($urandom_range(0, 15));
         if (r == 2) d = 16'($urandom);
         if (r < 12) rand_frame(ch, cmd, d, r == 3, 0, -1, 0);
         else if (r < 15) rand_frame(ch, cmd, d, 1'b0, 2, -1, 0);
         else if (r < 17) rand_frame(ch, cmd, d, 1'b0, 0, $urandom_range(0, 4),
                                     $urandom_range(Tmo - 2, Tmo + 2));
         else if (r == 17) send(8'($urandom_range(0, 255)));
         else if (r == 18) idle($urandom_range(1, 4));
         else begin
            send(8'hA5); send(ch);
            pulse_reset();
         end
      end
      idle(3);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
